reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised, scoreboarded register file for the datapath: `DEPTH = 2**ADDR_W` registers of `DATA_W` bits, two combinational read ports, one write-back port and one reservation port. The reservation port marks destination registers pending when an instruction issues; write-back clears the pending flag. Read ports report busy status so the hazard/stall logic can hold issue. Writes are single-edge (rising edge only), write-back is bypassed to the read ports, there is a real reset, and register 0 is optionally hard-wired to zero.

## Interface
Parameters:
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 4, address width; `DEPTH = 2**ADDR_W`
- `ZERO_REG`, 1, if 1 then register 0 always reads 0, ignores writes and is never busy

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `rd_addr1`, `rd_addr2`  in  ADDR_W  read addresses
- `rd_data1`, `rd_data2`  out  DATA_W  read data, combinational
- `rd_busy1`, `rd_busy2`  out  1  addressed register pending, combinational
- `rsv_en`  in  1  reserve request
- `rsv_addr`  in  ADDR_W  register to mark pending
- `rsv_ok`  out  1  reservation accepted this cycle, combinational
- `wb_en`  in  1  write-back enable
- `wb_addr`  in  ADDR_W  write-back address
- `wb_data`  in  DATA_W  write-back data
- `busy_count`  out  ADDR_W+1  number of pending registers, registered
- `wb_err`  out  1  sticky flag: write-back to a non-pending register

## Operation
- State: `regs[DEPTH]`, `busy[DEPTH]`, `busy_count`, `wb_err`.
- Define `z(a) = ZERO_REG && a == 0` and `hit(a) = wb_en && wb_addr == a && !z(a)`.
- Read port n:
  - `z(rd_addr)` → data 0, busy 0.
  - `hit(rd_addr)` → data `wb_data`, busy 0 (bypass).
  - Otherwise → `regs[rd_addr]`, `busy[rd_addr]`.
- Write-back, on the edge, if `wb_en && !z(wb_addr)`:
  - `regs[wb_addr] <= wb_data`.
  - `busy[wb_addr] <= 0`.
  - If `busy[wb_addr]` was 0, `wb_err <= 1`. `wb_err` stays set until reset.
  - The write still happens when `busy[wb_addr]` was 0.
- Write-back to register 0 with `ZERO_REG=1` is dropped and does not set `wb_err`.
- `rsv_ok = rsv_en && (z(rsv_addr) || !busy[rsv_addr] || hit(rsv_addr))`.
  - Reserving a pending register is rejected (`rsv_ok=0`) unless it is being written back in the same cycle.
- If `rsv_ok && !z(rsv_addr)`, then `busy[rsv_addr] <= 1` on the edge. Reserve takes priority over a same-address write-back clear: the register ends up busy, with the new data.
- `busy_count` updates by net change:
  - +1 for a set of a previously clear bit.
  - −1 for a clear of a previously set bit.
  - 0 when both happen on the same register.
  - It always equals `popcount(busy)` and never wraps, since its maximum is `DEPTH`.

## Timing
- Reset (asynchronous, at any time, including mid-operation): all `regs` 0, all `busy` 0, `busy_count` 0, `wb_err` 0.
  - While `reset` is high, `rsv_ok` is still combinational, but no state changes.
- Read latency 0 (combinational). Write and reserve take effect at the next rising edge and are visible on reads in the following cycle. Bypass covers the write cycle itself.
- No handshake back-pressure on write-back: every `wb_en` is accepted.
- A rejected reserve (`rsv_ok=0`) has no side effect. The requester holds `rsv_en`/`rsv_addr` and retries.
- Both read ports addressing the same register return identical values.

## Structure
- Package `reg_file_pkg`:
  - Default `DATA_W`/`ADDR_W` constants.
  - `reg_addr_t` and `reg_data_t` typedefs.
- Sub-module `reg_scoreboard`:
  - Holds `busy[]`, `busy_count`, `wb_err` and `rsv_ok` logic.
  - Parametrised by `ADDR_W` and `ZERO_REG`.
  - The top level holds the data array and the read/bypass muxes.

## Test plan
- Reset then read all addresses → every `rd_data`=0, `rd_busy`=0, `busy_count`=0, `wb_err`=0.
- Reserve r5, next cycle `rd_addr1`=5 → `rd_busy1`=1, `busy_count`=1. Write-back r5=0xDEADBEEF with `rd_addr1`=5 in the same cycle → `rd_data1`=0xDEADBEEF, `rd_busy1`=0. Next cycle → `busy_count`=0.
- r3 busy, reserve r3 → `rsv_ok`=0, count unchanged. Repeat with a write-back to r3 (0x12) in the same cycle → `rsv_ok`=1, r3 stays busy, reads 0x12 afterwards, `busy_count` unchanged.
- `ZERO_REG=1`: write-back r0=0xFFFF_FFFF, reserve r0 → `rsv_ok`=1, r0 reads 0, never busy, `busy_count`=0, `wb_err`=0.
- Write-back to non-busy r7 → r7 written, `wb_err`=1 and remains 1 through later traffic until `reset`.
- Reserve all 15 non-zero registers on consecutive cycles → `busy_count`=15. Assert `reset` mid-sequence, asynchronously between edges → all outputs return to 0 immediately.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared defaults and types for the scoreboarded register file.
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;

  typedef logic [DEF_DATA_W-1:0] reg_data_t;
  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-register scoreboard: busy bits, pending count, reservation
// acceptance and the sticky write-back-to-idle-register error flag.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  output logic [ADDR_W:0]   busy_count,
  output logic              wb_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] r_busy;
  logic [ADDR_W:0]  r_busy_count;
  logic             r_wb_err;

  logic [DEPTH-1:0] w_busy_nxt;
  logic             w_wb_act;
  logic             w_z_rsv;
  logic             w_hit_rsv;
  logic             w_set;
  logic             w_inc;
  logic             w_dec;

  // Register 0 is hard-wired when ZERO_REG is enabled.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // A write-back that actually lands in the array.
  assign w_wb_act  = wb_en && !is_zero(wb_addr);
  assign w_z_rsv   = is_zero(rsv_addr);
  assign w_hit_rsv = w_wb_act && (wb_addr == rsv_addr);

  // A pending register may be re-reserved only if it retires this cycle.
  assign rsv_ok = rsv_en && (w_z_rsv || !r_busy[rsv_addr] || w_hit_rsv);
  assign w_set  = rsv_ok && !w_z_rsv;

  // Net change of the pending population; a same-register clear+set nets zero.
  assign w_inc = w_set && !r_busy[rsv_addr];
  assign w_dec = w_wb_act && r_busy[wb_addr] && !(w_set && (rsv_addr == wb_addr));

  // Read-side busy: bypassed write-back data is never reported as pending.
  assign rd_busy1 = !is_zero(rd_addr1) && !(w_wb_act && (wb_addr == rd_addr1))
                    && r_busy[rd_addr1];
  assign rd_busy2 = !is_zero(rd_addr2) && !(w_wb_act && (wb_addr == rd_addr2))
                    && r_busy[rd_addr2];

  assign busy_count = r_busy_count;
  assign wb_err     = r_wb_err;

  // Next busy vector: write-back clears first, reservation set wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wb_act) w_busy_nxt[wb_addr] = 1'b0;
    if (w_set)    w_busy_nxt[rsv_addr] = 1'b1;
  end

  // Scoreboard state update.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_busy       <= '0;
      r_busy_count <= '0;
      r_wb_err     <= 1'b0;
    end else begin
      r_busy       <= w_busy_nxt;
      r_busy_count <= r_busy_count + {{ADDR_W{1'b0}}, w_inc}
                                   - {{ADDR_W{1'b0}}, w_dec};
      if (w_wb_act && !r_busy[wb_addr]) r_wb_err <= 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Scoreboarded register file: data array with write-back bypass on two
// combinational read ports; pending tracking lives in reg_scoreboard.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W:0]   busy_count,
  output logic              wb_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic              w_wb_act;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign w_wb_act = wb_en && !is_zero(wb_addr);

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clock      (clock),
    .reset      (reset),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .rd_busy1   (rd_busy1),
    .rd_busy2   (rd_busy2),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .rsv_ok     (rsv_ok),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .busy_count (busy_count),
    .wb_err     (wb_err)
  );

  // Data array: cleared on reset, written on accepted write-back.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (w_wb_act) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // Read muxes: hard zero, then same-cycle write-back bypass, then array.
  always_comb begin
    rd_data1 = r_regs[rd_addr1];
    rd_data2 = r_regs[rd_addr2];
    if (w_wb_act && (wb_addr == rd_addr1)) rd_data1 = wb_data;
    if (w_wb_act && (wb_addr == rd_addr2)) rd_data2 = wb_data;
    if (is_zero(rd_addr1)) rd_data1 = '0;
    if (is_zero(rd_addr2)) rd_data2 = '0;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: reset sweep, table of directed vectors checked
// through an expectation queue, and async-reset / fill sequences.
module tb_reg_file_sb;
  import reg_file_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  rd_addr1 = '0, rd_addr2 = '0, rsv_addr = '0, wb_addr = '0;
  logic [31:0] rd_data1, rd_data2, wb_data = '0;
  logic        rd_busy1, rd_busy2, rsv_ok, wb_err;
  logic        rsv_en = 1'b0, wb_en = 1'b0;
  logic [4:0]  busy_count;

  reg_file_sb #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1)) dut (
    .clock(clock), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy_count(busy_count), .wb_err(wb_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  a1, a2;
    logic        re;
    logic [3:0]  ra;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [31:0] d1;
    logic        b1;
    logic [31:0] d2;
    logic        b2;
    logic        ok;
    logic [4:0]  cnt;
    logic        err;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl[18];
  vec_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] a1, input logic [3:0] a2,
                              input logic re, input logic [3:0] ra,
                              input logic we, input logic [3:0] wa, input logic [31:0] wd,
                              input logic [31:0] d1, input logic b1,
                              input logic [31:0] d2, input logic b2,
                              input logic ok, input logic [4:0] cnt, input logic err);
    vec_t v;
    v.a1 = a1; v.a2 = a2; v.re = re; v.ra = ra; v.we = we; v.wa = wa; v.wd = wd;
    v.d1 = d1; v.b1 = b1; v.d2 = d2; v.b2 = b2; v.ok = ok; v.cnt = cnt; v.err = err;
    return v;
  endfunction

  task automatic idle();
    rsv_en = 1'b0; wb_en = 1'b0; rsv_addr = '0; wb_addr = '0; wb_data = '0;
  endtask

  // Drive one vector just after the edge, queue its expectation, check mid-cycle.
  task automatic apply(input int idx, input vec_t v);
    vec_t e;
    @(posedge clock); #1;
    rd_addr1 = v.a1; rd_addr2 = v.a2;
    rsv_en = v.re; rsv_addr = v.ra;
    wb_en = v.we; wb_addr = v.wa; wb_data = v.wd;
    exp_q.push_back(v);
    @(negedge clock);
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL v%0d.queue: got empty, want one entry", idx);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("v%0d.rd_data1", idx), rd_data1, e.d1);
      chk($sformatf("v%0d.rd_busy1", idx), {31'b0, rd_busy1}, {31'b0, e.b1});
      chk($sformatf("v%0d.rd_data2", idx), rd_data2, e.d2);
      chk($sformatf("v%0d.rd_busy2", idx), {31'b0, rd_busy2}, {31'b0, e.b2});
      chk($sformatf("v%0d.rsv_ok", idx), {31'b0, rsv_ok}, {31'b0, e.ok});
      chk($sformatf("v%0d.busy_count", idx), {27'b0, busy_count}, {27'b0, e.cnt});
      chk($sformatf("v%0d.wb_err", idx), {31'b0, wb_err}, {31'b0, e.err});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            a1 a2 re ra we wa wd            d1            b1 d2            b2 ok cnt err
    tbl[0]  = mk(5, 0, 1, 5, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 1, 0, 0);
    tbl[1]  = mk(5, 0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h0,        0, 0, 1, 0);
    tbl[2]  = mk(5, 5, 0, 0, 1, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 1, 0);
    tbl[3]  = mk(5, 3, 0, 0, 0, 0, 32'h0,        32'hDEADBEEF, 0, 32'h0,        0, 0, 0, 0);
    tbl[4]  = mk(3, 0, 1, 3, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 1, 0, 0);
    tbl[5]  = mk(3, 0, 1, 3, 0, 0, 32'h0,        32'h0,        1, 32'h0,        0, 0, 1, 0);
    tbl[6]  = mk(3, 0, 1, 3, 1, 3, 32'h12,       32'h12,       0, 32'h0,        0, 1, 1, 0);
    tbl[7]  = mk(3, 3, 0, 0, 0, 0, 32'h0,        32'h12,       1, 32'h12,       1, 0, 1, 0);
    tbl[8]  = mk(0, 0, 1, 0, 1, 0, 32'hFFFFFFFF, 32'h0,        0, 32'h0,        0, 1, 1, 0);
    tbl[9]  = mk(0, 3, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h12,       1, 0, 1, 0);
    tbl[10] = mk(7, 0, 0, 0, 1, 7, 32'hA5A5,     32'hA5A5,     0, 32'h0,        0, 0, 1, 0);
    tbl[11] = mk(7, 5, 0, 0, 0, 0, 32'h0,        32'hA5A5,     0, 32'hDEADBEEF, 0, 0, 1, 1);
    tbl[12] = mk(3, 9, 1, 9, 1, 3, 32'h34,       32'h34,       0, 32'h0,        0, 1, 1, 1);
    tbl[13] = mk(3, 9, 0, 0, 0, 0, 32'h0,        32'h34,       0, 32'h0,        1, 0, 1, 1);
    tbl[14] = mk(9, 0, 0, 0, 1, 9, 32'h99,       32'h99,       0, 32'h0,        0, 0, 1, 1);
    tbl[15] = mk(9, 0, 0, 0, 0, 0, 32'h0,        32'h99,       0, 32'h0,        0, 0, 0, 1);
    tbl[16] = mk(11, 0, 1, 11, 1, 11, 32'hB,     32'hB,        0, 32'h0,        0, 1, 0, 1);
    tbl[17] = mk(11, 0, 0, 0, 0, 0, 32'h0,       32'hB,        1, 32'h0,        0, 0, 1, 1);

    // Reset then sweep every address on both ports.
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    for (int a = 0; a < 16; a++) begin
      @(posedge clock); #1;
      idle(); rd_addr1 = 4'(a); rd_addr2 = 4'(15 - a);
      @(negedge clock);
      chk($sformatf("rst.rd_data1[%0d]", a), rd_data1, 32'h0);
      chk($sformatf("rst.rd_data2[%0d]", a), rd_data2, 32'h0);
      chk($sformatf("rst.rd_busy1[%0d]", a), {31'b0, rd_busy1}, 32'h0);
      chk($sformatf("rst.rd_busy2[%0d]", a), {31'b0, rd_busy2}, 32'h0);
    end
    chk("rst.busy_count", {27'b0, busy_count}, 32'h0);
    chk("rst.wb_err", {31'b0, wb_err}, 32'h0);

    for (int i = 0; i < 18; i++) apply(i, tbl[i]);

    // Asynchronous reset between edges clears the sticky error at once.
    @(posedge clock); #1; idle();
    #2 reset = 1'b1;
    #1;
    chk("areset1.wb_err", {31'b0, wb_err}, 32'h0);
    chk("areset1.busy_count", {27'b0, busy_count}, 32'h0);
    @(negedge clock); reset = 1'b0;

    // Write r4 while idle (sets wb_err), then reserve r1..r15 back to back.
    @(posedge clock); #1;
    wb_en = 1'b1; wb_addr = 4'd4; wb_data = 32'h44;
    for (int i = 1; i < 16; i++) begin
      @(posedge clock); #1;
      wb_en = 1'b0; rsv_en = 1'b1; rsv_addr = 4'(i);
      @(negedge clock);
      chk($sformatf("fill.rsv_ok[%0d]", i), {31'b0, rsv_ok}, 32'h1);
      chk($sformatf("fill.busy_count[%0d]", i), {27'b0, busy_count}, 32'(i - 1));
    end
    @(posedge clock); #1;
    rsv_en = 1'b1; rsv_addr = 4'd1; rd_addr1 = 4'd4; rd_addr2 = 4'd15;
    @(negedge clock);
    chk("full.busy_count", {27'b0, busy_count}, 32'd15);
    chk("full.rsv_ok_busy_r1", {31'b0, rsv_ok}, 32'h0);
    chk("full.rd_data1_r4", rd_data1, 32'h44);
    chk("full.rd_busy2_r15", {31'b0, rd_busy2}, 32'h1);
    chk("full.wb_err", {31'b0, wb_err}, 32'h1);

    // Mid-cycle asynchronous reset: outputs drop immediately.
    @(posedge clock); #1;
    rsv_addr = 4'd2;
    #2 reset = 1'b1;
    #1;
    chk("areset2.busy_count", {27'b0, busy_count}, 32'h0);
    chk("areset2.wb_err", {31'b0, wb_err}, 32'h0);
    chk("areset2.rd_data1", rd_data1, 32'h0);
    chk("areset2.rd_busy2", {31'b0, rd_busy2}, 32'h0);
    chk("areset2.rsv_ok_comb", {31'b0, rsv_ok}, 32'h1);

    // Reserve held across an edge during reset must not change state.
    rd_addr1 = 4'd2;
    @(posedge clock); #1;
    chk("inreset.busy_count", {27'b0, busy_count}, 32'h0);
    chk("inreset.rd_busy1", {31'b0, rd_busy1}, 32'h0);
    @(negedge clock); reset = 1'b0; idle();
    @(posedge clock); #1;
    chk("postreset.busy_count", {27'b0, busy_count}, 32'h0);
    chk("postreset.rd_busy1", {31'b0, rd_busy1}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
